program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 6: instruction-memory word-address width; word capacity is 2^ADDR_W, 64 at default.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level-sampled request to begin a load session; honoured only in IDLE.
REQ-005 word_count  input  ADDR_W  number of words to load, sampled on accepted start; 0 means 2^ADDR_W.
REQ-006 byte_valid  input  1  source presents byte_data.
REQ-007 byte_data  input  8  program byte stream, most significant byte of each word first.
REQ-008 byte_ready  output  1  loader accepts byte; a transfer occurs on any cycle with byte_valid=1 and byte_ready=1.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 mem_data  output  32  assembled instruction word.
REQ-012 hold  output  1  drives processor HLT; freezes PC while loading.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  one-cycle pulse at end of session.
REQ-015 error  output  1  sticky checksum-mismatch flag (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE, CHECK, FINISH; CHECK exists only with the macro defined.
REQ-017 IDLE: byte_ready=0, hold=0, busy=0; start=1 SHALL latch word_count, clear word and byte indices, clear error, and go to RECV next cycle.
REQ-018 RECV: byte_ready=1, hold=1, busy=1; each transfer SHALL place byte_data into lane 3-byte_idx of the word register (first byte to [31:24]) and increment byte_idx modulo 4.
REQ-019 The fourth transfer of a word SHALL move the FSM to WRITE on the next edge; byte_valid=0 cycles SHALL stall without state change.
REQ-020 WRITE: byte_ready=0, mem_we=1 for exactly one cycle, mem_addr=word_idx, mem_data=assembled word.
REQ-021 After WRITE, word_idx SHALL increment; if the written word was the last, go to CHECK (macro defined) or FINISH; otherwise return to RECV.
REQ-022 Last-word test SHALL be word_idx == latched_count-1 in ADDR_W-bit wrap arithmetic, so count 0 loads addresses 0..2^ADDR_W-1 exactly.
REQ-023 FINISH: done=1 for one cycle, hold=1, busy=1; next state IDLE, where hold falls.
REQ-024 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_data SHALL hold their last values outside WRITE.
REQ-025 start asserted in any state other than IDLE SHALL be ignored; start held high during FINISH SHALL begin a new session only after one IDLE cycle.
REQ-026 Write latency: mem_we SHALL assert on the cycle immediately after the edge that accepts the fourth byte.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE from any state, including mid-word or mid-session, discarding the partial word.
REQ-028 Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_data=0, hold=0, busy=0, done=0, error=0, indices 0.
REQ-029 reset SHALL take priority over start and byte transfers in the same cycle.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: after the last WRITE, CHECK SHALL accept one extra byte (byte_ready=1) and compare it with the XOR of all program bytes of the session; mismatch SHALL set error=1, which stays set until the next accepted start or reset; then FINISH.
REQ-031 Macro undefined: no CHECK state, no extra byte, error tied to 0.

Verification
REQ-032 reset, start with word_count=2, bytes 12 34 56 78 9A BC DE F0 -> mem_we pulses with addr 0 data 0x12345678, then addr 1 data 0x9ABCDEF0, done one cycle, hold high from cycle after start through FINISH.
REQ-033 word_count=1, byte_valid toggled 1/0 every cycle -> byte_ready honoured only on valid cycles, single write addr 0 after four transfers, no extra writes.
REQ-034 word_count=0 (ADDR_W=6), 256 bytes -> 64 writes, addresses 0..63 ascending, done after addr 63, no write to addr 0 twice.
REQ-035 reset asserted after two bytes of word 0 -> outputs at reset values next cycle, no mem_we; new session then writes first full word to addr 0.
REQ-036 LOADER_CHECKSUM_EN defined, word_count=1, bytes 01 02 04 08 then 0x0F -> error=0; repeat with check byte 0x00 -> error=1 after FINISH, cleared on next start.
REQ-037 start pulsed during RECV -> no effect on indices or latched count; session completes normally.

Source files
------------

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte-stream input and instruction-memory write bundle for the program loader
interface program_loader_if #(
   parameter int ADDR_W = 6
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;

   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output mem_we,
      output mem_addr,
      output mem_data
   );

   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_data
   );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles a big-endian byte stream into 32-bit words and writes them to instruction memory
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module program_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] word_count,
   program_loader_if.master  bus,
   output logic              hold,
   output logic              busy,
   output logic              done,
   output logic              error
);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RECV   = 3'd1,
      S_WRITE  = 3'd2,
      S_CHECK  = 3'd3,
      S_FINISH = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RECV   = 3'd1,
      S_WRITE  = 3'd2,
      S_FINISH = 3'd4
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [31:0]       mem_data_q, mem_data_d;
   logic              byte_ready;
   logic              mem_we;
   logic              xfer;
   logic              last_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        xsum_q, xsum_d;
   logic              error_q, error_d;
`endif

   assign xfer      = bus.byte_valid & byte_ready;
   // Wrap arithmetic makes a latched count of 0 mean the full 2^ADDR_W words.
   assign last_word = (word_idx_q == (count_q - ADDR_W'(1)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_RECV;
         S_RECV:   if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
         S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
            state_d = last_word ? S_CHECK : S_RECV;
`else
            state_d = last_word ? S_FINISH : S_RECV;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK:  if (xfer) state_d = S_FINISH;
`endif
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      hold       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_RECV: begin
            byte_ready = 1'b1;
            hold       = 1'b1;
            busy       = 1'b1;
         end
         S_WRITE: begin
            mem_we = 1'b1;
            hold   = 1'b1;
            busy   = 1'b1;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            byte_ready = 1'b1;
            hold       = 1'b1;
            busy       = 1'b1;
         end
`endif
         S_FINISH: begin
            done = 1'b1;
            hold = 1'b1;
            busy = 1'b1;
         end
         default: begin
            byte_ready = 1'b0;
         end
      endcase
   end

   always_comb begin
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
`ifdef LOADER_CHECKSUM_EN
      xsum_d     = xsum_q;
      error_d    = error_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d    = word_count;
               word_idx_d = '0;
               byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
               xsum_d     = '0;
               error_d    = 1'b0;
`endif
            end
         end
         S_RECV: begin
            if (xfer) begin
               // Lane 3-byte_idx: the first byte of a word lands in [31:24].
               word_d[{~byte_idx_q, 3'b000} +: 8] = bus.byte_data;
               byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               xsum_d = xsum_q ^ bus.byte_data;
`endif
               if (byte_idx_q == 2'd3) begin
                  mem_addr_d = word_idx_q;
                  mem_data_d = {word_q[31:8], bus.byte_data};
               end
            end
         end
         S_WRITE: begin
            word_idx_d = word_idx_q + ADDR_W'(1);
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer && bus.byte_data != xsum_q) error_d = 1'b1;
         end
`endif
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         xsum_q     <= '0;
         error_q    <= 1'b0;
`endif
      end else begin
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
`ifdef LOADER_CHECKSUM_EN
         xsum_q     <= xsum_d;
         error_q    <= error_d;
`endif
      end
   end

   assign bus.byte_ready = byte_ready;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_data   = mem_data_q;
`ifdef LOADER_CHECKSUM_EN
   assign error = error_q;
`else
   assign error = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;
   localparam int ADDR_W = 6;
`ifdef LOADER_CHECKSUM_EN
   localparam int CHK_EN = 1;
`else
   localparam int CHK_EN = 0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] word_count;
   logic              hold, busy, done, error;

   program_loader_if #(.ADDR_W(ADDR_W)) bus ();

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .bus        (bus),
      .hold       (hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   int pass_cnt = 0;
   int total_cnt = 0;
   int done_cnt = 0;
   int xfer_cnt = 0;
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   logic [31:0]       exp_words[$];

   always @(negedge clock) begin
      if (bus.mem_we) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_data);
      end
      if (done) done_cnt++;
      if (bus.byte_valid && bus.byte_ready) xfer_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
      xfer_cnt = 0;
   endtask

   // gap: 0 = back-to-back, 1 = one idle cycle before every byte, 2 = random idle cycles
   task automatic push_byte(input logic [7:0] b, input int gap);
      int n = 0;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
         bus.byte_valid = 1'b0;
         @(posedge clock); #1;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (!bus.byte_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= 50) check("byte_ready_wait", n, 0);
      @(posedge clock); #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int c = 0;
      while (!done && c < 20) begin
         @(posedge clock); #1;
         c++;
      end
      check({tag, "_done_seen"}, done, 1);
      check({tag, "_hold_at_done"}, hold, 1);
   endtask

   task automatic run_session(input logic [ADDR_W-1:0] cnt, input int gap, input int poke,
                              input int exp_n, input int bad, input string tag);
      logic [7:0] xsum = 8'h00;
      logic [7:0] b;
      int lat_bad = 0;
      int seq_bad = 0;
      int k = 0;
      clear_mon();
      start = 1'b1;
      word_count = cnt;
      @(posedge clock); #1;
      start = 1'b0;
      word_count = ~cnt;
      check({tag, "_hold_on"}, hold, 1);
      check({tag, "_err_clr"}, error, 0);
      for (int w = 0; w < exp_n; w++) begin
         for (int i = 0; i < 4; i++) begin
            b = exp_words[w][31-8*i -: 8];
            xsum ^= b;
            if (k == poke) start = 1'b1;
            push_byte(b, gap);
            start = 1'b0;
            k++;
            if (i == 3 && !(bus.mem_we === 1'b1 && bus.mem_addr === w[ADDR_W-1:0]
                            && bus.mem_data === exp_words[w])) lat_bad++;
         end
      end
      if (CHK_EN != 0) push_byte(bad != 0 ? ((xsum == 8'h00) ? 8'hFF : 8'h00) : xsum, 0);
      wait_done(tag);
      @(posedge clock); #1;
      check({tag, "_idle_hold"}, {hold, busy, bus.byte_ready}, 0);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_n_writes"}, wr_addr.size(), exp_n);
      for (int i = 0; i < wr_addr.size() && i < exp_n; i++)
         if (wr_addr[i] !== i[ADDR_W-1:0] || wr_data[i] !== exp_words[i]) seq_bad++;
      check({tag, "_write_seq"}, seq_bad, 0);
      check({tag, "_latency"}, lat_bad, 0);
      check({tag, "_transfers"}, xfer_cnt, 4 * exp_n + CHK_EN);
      check({tag, "_error"}, error, (CHK_EN != 0 && bad != 0) ? 1 : 0);
   endtask

   typedef struct {
      logic [ADDR_W-1:0] cnt;
      int                gap;
      int                poke;
      logic [31:0]       w0;
      logic [31:0]       w1;
      int                exp_n;
      int                bad;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] x;
      int         n;
      vecs[0] = '{6'd2, 0, -1, 32'h12345678, 32'h9ABCDEF0, 2,  0};
      vecs[1] = '{6'd1, 1, -1, 32'hCAFEBABE, 32'h00000000, 1,  0};
      vecs[2] = '{6'd0, 0, -1, 32'h00000001, 32'hFFFFFFFF, 64, 0};
      vecs[3] = '{6'd3, 2, 5,  32'hA5A55A5A, 32'h01020408, 3,  0};
      vecs[4] = '{6'd1, 0, -1, 32'h01020408, 32'h00000000, 1,  0};
      vecs[5] = '{6'd1, 0, -1, 32'h01020408, 32'h00000000, 1,  1};

      reset = 1'b1;
      start = 1'b0;
      word_count = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      check("rst_byte_ready", bus.byte_ready, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_data", bus.mem_data, 0);
      check("rst_flags", {hold, busy, done, error}, 0);

      start = 1'b1;
      word_count = 6'd1;
      @(posedge clock); #1;
      check("rst_over_start", {hold, busy}, 0);
      reset = 1'b0;
      start = 1'b0;
      @(posedge clock); #1;

      for (int v = 0; v < 6; v++) begin
         exp_words.delete();
         exp_words.push_back(vecs[v].w0);
         exp_words.push_back(vecs[v].w1);
         while (exp_words.size() < vecs[v].exp_n) exp_words.push_back($urandom());
         run_session(vecs[v].cnt, vecs[v].gap, vecs[v].poke, vecs[v].exp_n, vecs[v].bad,
                     $sformatf("vec%0d", v));
      end

      for (int r = 0; r < 5; r++) begin
         logic [ADDR_W-1:0] c;
         c = ADDR_W'($urandom_range(1, 7));
         exp_words.delete();
         for (int i = 0; i < int'(c); i++) exp_words.push_back($urandom());
         run_session(c, 2, -1, int'(c), int'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
      end

      // reset after two bytes of the first word
      clear_mon();
      start = 1'b1;
      word_count = 6'd1;
      @(posedge clock); #1;
      start = 1'b0;
      push_byte(8'hDE, 0);
      push_byte(8'hAD, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midrst_flags", {hold, busy, done, error, bus.byte_ready, bus.mem_we}, 0);
      check("midrst_mem", {bus.mem_addr, bus.mem_data[25:0]}, 0);
      check("midrst_data_hi", bus.mem_data[31:26], 0);
      @(posedge clock); #1;
      check("midrst_no_write", wr_addr.size(), 0);
      exp_words.delete();
      exp_words.push_back(32'h11223344);
      run_session(6'd1, 0, -1, 1, 0, "postrst");

      // start held high through FINISH restarts only after one IDLE cycle
      clear_mon();
      exp_words.delete();
      exp_words.push_back(32'h0BADF00D);
      exp_words.push_back(32'hFEEDC0DE);
      start = 1'b1;
      word_count = 6'd1;
      @(posedge clock); #1;
      start = 1'b0;
      x = 8'h00;
      for (int i = 0; i < 4; i++) begin
         x ^= exp_words[0][31-8*i -: 8];
         push_byte(exp_words[0][31-8*i -: 8], 0);
      end
      if (CHK_EN != 0) push_byte(x, 0);
      start = 1'b1;
      wait_done("hs");
      @(posedge clock); #1;
      check("hs_idle_gap", busy, 0);
      @(posedge clock); #1;
      check("hs_restart", busy, 1);
      start = 1'b0;
      x = 8'h00;
      for (int i = 0; i < 4; i++) begin
         x ^= exp_words[1][31-8*i -: 8];
         push_byte(exp_words[1][31-8*i -: 8], 0);
      end
      if (CHK_EN != 0) push_byte(x, 0);
      wait_done("hs2");
      @(posedge clock); #1;
      n = wr_data.size();
      check("hs_n_writes", n, 2);
      if (n == 2) begin
         check("hs_w1_addr", wr_addr[1], 0);
         check("hs_w1_data", wr_data[1], exp_words[1]);
      end
      check("hs_error", error, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
